float_mul_seq: RTL

//  Parametrised sequential IEEE-754 multiplier: shift-add mantissa product, one multiplier bit per cycle.

---
 rtl/float_mul_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/float_mul_seq.sv
// Sequential IEEE-754 multiplier: shift-add significand product (one multiplier
// bit per cycle), round-to-nearest-even, flush-to-zero of subnormals, and
// overflow/underflow/invalid/inexact flags. Valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | shift-add of one multiplier bit per cycle
// RND   | normalise, round, detect range exceptions
// DONE  | result held on s/flags until out_ready
module float_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         overflow,
   output logic         underflow,
   output logic         invalid,
   output logic         inexact
);

   localparam int SW  = MAN_W + 1;
   localparam int PW  = 2 * SW;
   localparam int EW2 = EXP_W + 2;
   localparam int CW  = $clog2(SW + 1);
   localparam logic [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
   localparam logic [W-1:0]   QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;
   state_t state_q, state_d;

   logic           sign_q;
   logic [PW-1:0]  mcand_q;
   logic [SW-1:0]  mplier_q;
   logic [PW-1:0]  acc_q;
   logic [EW2-1:0] exp_q;
   logic [CW-1:0]  cnt_q;

   // operand classification (subnormals count as zero)
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, accept, sgn_in;

   assign a_exp   = a[W-2 -: EXP_W];
   assign b_exp   = b[W-2 -: EXP_W];
   assign a_frac  = a[MAN_W-1:0];
   assign b_frac  = b[MAN_W-1:0];
   assign a_nan   = (&a_exp) & (|a_frac);
   assign b_nan   = (&b_exp) & (|b_frac);
   assign a_inf   = (&a_exp) & ~(|a_frac);
   assign b_inf   = (&b_exp) & ~(|b_frac);
   assign a_zero  = ~(|a_exp);
   assign b_zero  = ~(|b_exp);
   assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign sgn_in  = a[W-1] ^ b[W-1];
   assign accept  = in_valid & in_ready;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // special-operand result selection
   logic [W-1:0] sp_s;
   logic         sp_inv;
   always_comb begin
      sp_s   = '0;
      sp_inv = 1'b0;
      if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
         sp_s   = QNAN;
         sp_inv = 1'b1;
      end else if (a_inf | b_inf) begin
         sp_s = {sgn_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
         sp_s = {sgn_in, {(W-1){1'b0}}};
      end
   end

   // normalise, round to nearest even, and range-check the finished product
   logic [PW-1:0]    norm;
   logic [SW-1:0]    mant;
   logic             guard, sticky, rbit;
   logic [SW:0]      mant_rnd;
   logic [EW2-1:0]   exp_n, exp_fin;
   logic [MAN_W-1:0] frac_fin;
   logic             r_ovf, r_unf;
   logic [W-1:0]     r_s;
   logic             r_inx;
   always_comb begin
      norm     = acc_q[PW-1] ? acc_q : (acc_q << 1);
      exp_n    = exp_q + EW2'(acc_q[PW-1]);
      mant     = norm[PW-1 -: SW];
      guard    = norm[SW-1];
      sticky   = |norm[SW-2:0];
      rbit     = guard & (sticky | mant[0]);
      mant_rnd = {1'b0, mant} + {{SW{1'b0}}, rbit};
      exp_fin  = exp_n + EW2'(mant_rnd[SW]);
      frac_fin = mant_rnd[SW] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
      r_ovf    = ~exp_fin[EW2-1] & (exp_fin >= EXP_MAX);
      r_unf    = exp_fin[EW2-1] | (exp_fin == '0);
      r_inx    = guard | sticky;
      r_s      = {sign_q, exp_fin[EXP_W-1:0], frac_fin};
      if (r_ovf) begin
         r_s   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         r_inx = 1'b1;
      end else if (r_unf) begin
         r_s   = {sign_q, {(W-1){1'b0}}};
         r_inx = 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state decode; counter at 1 means the last multiplier bit is being added
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = special ? DONE : MUL;
         MUL:     if (cnt_q == CW'(1)) state_d = RND;
         RND:     state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath: operand capture, shift-add iterations, result/flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q    <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         exp_q     <= '0;
         cnt_q     <= '0;
         s         <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: if (accept) begin
               sign_q    <= sgn_in;
               mcand_q   <= {{SW{1'b0}}, 1'b1, a_frac};
               mplier_q  <= {1'b1, b_frac};
               acc_q     <= '0;
               exp_q     <= EW2'(a_exp) + EW2'(b_exp) - BIAS;
               cnt_q     <= CW'(SW);
               overflow  <= 1'b0;
               underflow <= 1'b0;
               inexact   <= 1'b0;
               invalid   <= special & sp_inv;
               s         <= special ? sp_s : '0;
            end
            MUL: begin
               acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CW'(1);
            end
            RND: begin
               s         <= r_s;
               overflow  <= r_ovf;
               underflow <= r_unf;
               inexact   <= r_inx;
            end
            default: ;
         endcase
      end
   end

endmodule
